// File: rtl/period_meter.sv
// Period and high-time meter for an asynchronous input, measured in clk_in cycles.
// Results are offered on a valid/ready handshake; a result arriving while one is stalled is dropped.
module period_meter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 180000000
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             sig_in,
  input  logic             meas_ready_in,
  output logic             meas_valid_out,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             timeout_out,
  output logic             overrun_out
);

  typedef enum logic {StIdle, StMeasure} state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  logic             r_sync1, r_sync2, r_sync3;
  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_high_cnt, w_high_cnt_d;
  logic             r_fall_seen, w_fall_seen_d;
  logic             r_valid, r_timeout, r_overrun;
  logic [CNT_W-1:0] r_period, r_high;
  logic             w_rise, w_fall, w_done, w_timeout;

  assign w_rise = r_sync2 & ~r_sync3;
  assign w_fall = ~r_sync2 & r_sync3;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_high_cnt  <= '0;
      r_fall_seen <= 1'b0;
    end else begin
      r_sync1     <= sig_in;
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_high_cnt  <= w_high_cnt_d;
      r_fall_seen <= w_fall_seen_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_high_cnt_d  = r_high_cnt;
    w_fall_seen_d = r_fall_seen;
    w_done        = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_d     = StMeasure;
          w_cnt_d       = CntOne;
          w_high_cnt_d  = '0;
          w_fall_seen_d = 1'b0;
        end
      end
      StMeasure: begin
        // A rise on the timeout cycle still completes the measurement.
        if (w_rise) begin
          w_done        = 1'b1;
          w_cnt_d       = CntOne;
          w_high_cnt_d  = '0;
          w_fall_seen_d = 1'b0;
        end else if (r_cnt >= TimeoutVal) begin
          w_timeout     = 1'b1;
          w_state_d     = StIdle;
          w_cnt_d       = '0;
        end else begin
          w_cnt_d = r_cnt + CntOne;
          if (w_fall && !r_fall_seen) begin
            w_high_cnt_d  = r_cnt;
            w_fall_seen_d = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid   <= 1'b0;
      r_period  <= '0;
      r_high    <= '0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      r_overrun <= 1'b0;
      if (w_done && (!r_valid || meas_ready_in)) begin
        r_valid  <= 1'b1;
        r_period <= r_cnt;
        r_high   <= r_high_cnt;
      end else if (w_done) begin
        r_overrun <= 1'b1;
      end else if (r_valid && meas_ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign meas_valid_out = r_valid;
  assign period_out     = r_period;
  assign high_out       = r_high;
  assign timeout_out    = r_timeout;
  assign overrun_out    = r_overrun;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: square-wave vector table plus handshake, timeout
// and reset corner sequences, with results checked against a scoreboard queue.
module tb_period_meter;

  localparam int unsigned CW = 16;
  localparam int unsigned TO = 100;

  typedef struct {
    int unsigned period;
    int unsigned high;
    int unsigned n;
  } vec_t;

  typedef struct {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
  } res_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          sig   = 1'b0;
  logic          ready = 1'b0;
  logic          valid;
  logic [CW-1:0] period;
  logic [CW-1:0] high;
  logic          timeout;
  logic          overrun;

  int errors    = 0;
  int checks    = 0;
  int n_timeout = 0;
  int n_overrun = 0;
  res_t sb[$];
  vec_t vecs[5];

  period_meter #(
    .CNT_W      (CW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .sig_in        (sig),
    .meas_ready_in (ready),
    .meas_valid_out(valid),
    .period_out    (period),
    .high_out      (high),
    .timeout_out   (timeout),
    .overrun_out   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned p, input int unsigned h);
    res_t r;
    r.period = CW'(p);
    r.high   = CW'(h);
    sb.push_back(r);
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected result.
  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      if (timeout) n_timeout++;
      if (overrun) n_overrun++;
      if (valid && ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got period %0d high %0d expected none", period, high);
        end else begin
          e = sb.pop_front();
          check("result_period", 32'(period), 32'(e.period));
          check("result_high", 32'(high), 32'(e.high));
        end
      end
    end
  end

  task automatic drive_wave(input int unsigned p, input int unsigned h, input int unsigned n);
    for (int k = 0; k <= int'(n); k++) begin
      if (k > 0) push(p, h);
      sig = 1'b1;
      repeat (h) step();
      sig = 1'b0;
      repeat (p - h) step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0, o0, first_to, to_cycles;

    vecs[0] = '{period: 10,  high: 4,  n: 4};
    vecs[1] = '{period: 3,   high: 1,  n: 5};
    vecs[2] = '{period: 7,   high: 3,  n: 3};
    vecs[3] = '{period: 20,  high: 10, n: 3};
    vecs[4] = '{period: TO,  high: 50, n: 2};

    // Reset state
    rst_n = 1'b0;
    sig   = 1'b1;
    step();
    step();
    check("rst_valid", 32'(valid), 0);
    check("rst_period", 32'(period), 0);
    check("rst_high", 32'(high), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_overrun", 32'(overrun), 0);

    // Input high at release: reference only; fall at c=4, next rise at c=10
    ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rst_n = 1'b1;
      sig   = (c < 4) || (c >= 10 && c < 14);
      if (c == 10) push(10, 4);
      step();
    end
    sig = 1'b0;
    repeat (120) step();
    check("hi_at_release_drained", 32'(sb.size()), 0);

    // Table-driven square waves; each ends with a single timeout back to idle
    foreach (vecs[i]) begin
      t0 = n_timeout;
      drive_wave(vecs[i].period, vecs[i].high, vecs[i].n);
      repeat (120) step();
      check("vec_timeouts", 32'(n_timeout - t0), 1);
      check("vec_valid_clear", 32'(valid), 0);
      check("vec_drained", 32'(sb.size()), 0);
    end

    // Exact timeout timing: single rise then held low
    t0        = n_timeout;
    first_to  = 0;
    to_cycles = 0;
    sig       = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      step();
      if (k == 2) sig = 1'b0;
      if (timeout) begin
        to_cycles++;
        if (first_to == 0) first_to = k;
      end
    end
    check("timeout_cycle", 32'(first_to), 103);
    check("timeout_width", 32'(to_cycles), 1);
    sig = 1'b1;
    repeat (4) step();
    sig = 1'b0;
    repeat (120) step();
    check("timeout_count", 32'(n_timeout - t0), 2);
    check("timeout_no_result", 32'(valid), 0);

    // Backpressure: first result held, second dropped with overrun
    o0 = n_overrun;
    for (int c = 0; c < 50; c++) begin
      sig   = (c < 24) && ((c % 10) < 4);
      ready = (c >= 35);
      if (c == 10) push(10, 4);
      if (c == 30) begin
        check("hold_valid", 32'(valid), 1);
        check("hold_period", 32'(period), 10);
        check("hold_high", 32'(high), 4);
      end
      step();
    end
    repeat (120) step();
    check("overrun_count", 32'(n_overrun - o0), 1);
    check("bp_valid_clear", 32'(valid), 0);
    check("bp_drained", 32'(sb.size()), 0);

    // Ready exactly on the completion cycle of the second result
    o0 = n_overrun;
    for (int c = 0; c < 50; c++) begin
      sig   = (c < 4) || (c >= 10 && c < 14) || (c >= 22 && c < 26);
      ready = (c == 24) || (c >= 40);
      if (c == 10) push(10, 4);
      if (c == 22) push(12, 4);
      if (c == 26) begin
        check("simul_valid", 32'(valid), 1);
        check("simul_period", 32'(period), 12);
      end
      step();
    end
    repeat (120) step();
    check("simul_overrun", 32'(n_overrun - o0), 0);
    check("simul_drained", 32'(sb.size()), 0);

    // Reset midway through a period-20 wave
    ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      sig   = (c < 90) && ((c % 20) < 10);
      rst_n = !(c >= 30 && c < 33);
      if (c == 20 || c == 60 || c == 80) push(20, 10);
      if (c == 32) begin
        check("midrst_valid", 32'(valid), 0);
        check("midrst_period", 32'(period), 0);
        check("midrst_high", 32'(high), 0);
        check("midrst_timeout", 32'(timeout), 0);
        check("midrst_overrun", 32'(overrun), 0);
      end
      step();
    end
    repeat (120) step();
    check("midrst_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
